// File: rtl/csa_seq_pkg.sv
// rtl/csa_seq_pkg.sv - shared types and constants for the multi-precision add sequencer
package csa_seq_pkg;

  localparam int ADDER_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/carry_skip16bit.sv
// rtl/carry_skip16bit.sv - 16-bit carry-skip adder, four 4-bit ripple blocks with skip muxes
module carry_skip16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic       w_c;
  logic       w_rc;
  logic       w_prop;
  logic [3:0] w_k;
  logic [15:0] w_sum;

  // A block whose bits all propagate forwards its incoming carry directly.
  always_comb begin
    w_sum  = '0;
    w_c    = cin;
    w_rc   = 1'b0;
    w_prop = 1'b0;
    w_k    = '0;
    for (int blk = 0; blk < 4; blk++) begin
      w_rc   = w_c;
      w_prop = 1'b1;
      for (int i = 0; i < 4; i++) begin
        w_k        = 4'(blk * 4 + i);
        w_sum[w_k] = a[w_k] ^ b[w_k] ^ w_rc;
        w_rc       = (a[w_k] & b[w_k]) | ((a[w_k] ^ b[w_k]) & w_rc);
        w_prop     = w_prop & (a[w_k] ^ b[w_k]);
      end
      w_c = w_prop ? w_c : w_rc;
    end
  end

  assign sum  = w_sum;
  assign cout = w_c;

endmodule

// File: rtl/csa_mp_sequencer.sv
// rtl/csa_mp_sequencer.sv - WORDS x 16-bit add sequencer over one shared carry-skip adder
// Optional subtract mode (op port) when CSA_MP_SEQ_SUB_EN is defined.
module csa_mp_sequencer
  import csa_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef CSA_MP_SEQ_SUB_EN
  input  logic                       op,
`endif
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDER_W*WORDS-1:0]   a,
  input  logic [ADDER_W*WORDS-1:0]   b,
  input  logic                       cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDER_W*WORDS-1:0]   sum,
  output logic                       cout,
  output logic                       busy
);

  localparam int N     = ADDER_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic [N-1:0]       r_sum;
  logic               r_cout;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [ADDER_W-1:0] w_a_word;
  logic [ADDER_W-1:0] w_b_word;
  logic [ADDER_W-1:0] w_add_sum;
  logic               w_add_cout;
  logic               w_last;

  assign w_a_word = r_a[r_idx * ADDER_W +: ADDER_W];
  assign w_b_word = r_b[r_idx * ADDER_W +: ADDER_W];
  assign w_last   = (r_idx == IDX_W'(WORDS - 1));

  carry_skip16bit u_adder (
    .a    (w_a_word),
    .b    (w_b_word),
    .cin  (r_carry),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a <= a;
`ifdef CSA_MP_SEQ_SUB_EN
            // Subtract as a + ~b + 1; cout then reads as "no borrow".
            r_b     <= op ? ~b : b;
            r_carry <= op ? 1'b1 : cin;
`else
            r_b     <= b;
            r_carry <= cin;
`endif
            r_idx      <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          r_sum[r_idx * ADDER_W +: ADDER_W] <= w_add_sum;
          r_carry <= w_add_cout;
          if (w_last) begin
            r_cout      <= w_add_cout;
            r_idx       <= '0;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_csa_mp_sequencer.sv
// tb/tb_csa_mp_sequencer.sv - scoreboard bench for csa_mp_sequencer (WORDS=4)
module tb_csa_mp_sequencer;

  localparam int WORDS = 4;
  localparam int N     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] sum;
  logic         cout;
  logic         busy;

  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd_ready = 1'b0;
  logic prev_ov = 1'b0;

  csa_mp_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CSA_MP_SEQ_SUB_EN
    .op        (op),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                       input logic ci, input logic sub);
    if (sub) return {1'b0, x} + {1'b0, ~y} + 65'(1);
    return {1'b0, x} + {1'b0, y} + 65'(ci);
  endfunction

  task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h expected=none", sum);
      end else begin
        if (!prev_ov) check("latency", 65'(cyc - q[0].acc), 65'(WORDS));
        check("sum", {1'b0, sum}, {1'b0, q[0].sum});
        check("cout", 65'(cout), 65'(q[0].cout));
        check("in_ready_in_done", 65'(in_ready), 65'(0));
        if (out_ready) void'(q.pop_front());
      end
    end
    prev_ov <= out_valid && !rst;
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci,
                      input logic sub, input bit push);
    logic [N:0] r;
    exp_t       e;
    bit         ok;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = ci;
    op = sub;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low expected=accept");
    end
    r = model(x, y, ci, sub);
    e.sum = r[N-1:0];
    e.cout = r[N];
    e.acc = cyc + 1;
    if (push && ok) q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout actual=%0d expected=0 pending", q.size());
  endtask

  initial begin
    logic [N-1:0] x;
    logic [N-1:0] y;
    bit           seen;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 65'(in_ready), 65'(1));
    check("reset_out_valid", 65'(out_valid), 65'(0));
    check("reset_busy", 65'(busy), 65'(0));
    check("reset_sum", {1'b0, sum}, 65'(0));
    check("reset_cout", 65'(cout), 65'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    send(64'h5, 64'h5, 1'b1, 1'b0, 1'b1);
    send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b1);
    wait_idle();

    rnd_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if (t % 4 == 1) x = '1;
      if (t % 4 == 2) y = ~x;
      send(x, y, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    wait_idle();
    @(posedge clk);
    #1;
    rnd_ready = 1'b0;
    out_ready = 1'b0;

    // Back-pressure in DONE with a competing operand bundle on the input.
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 expected=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 64'hAAAA_0000_5555_FFFF;
    b = 64'h5555_FFFF_AAAA_0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 65'(out_valid), 65'(1));
      check("bp_in_ready", 65'(in_ready), 65'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(64'hAAAA_0000_5555_FFFF, 64'h5555_FFFF_AAAA_0001, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Reset after two RUN words discards the partial result.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", 65'(in_ready), 65'(1));
    check("rst_mid_out_valid", 65'(out_valid), 65'(0));
    check("rst_mid_busy", 65'(busy), 65'(0));
    check("rst_mid_sum", {1'b0, sum}, 65'(0));
    check("rst_mid_cout", 65'(cout), 65'(0));
    send(64'hC61F, 64'h18C, 1'b1, 1'b0, 1'b1);
    wait_idle();

`ifdef CSA_MP_SEQ_SUB_EN
    send(64'h10, 64'h1, 1'b0, 1'b1, 1'b1);
    send(64'h0, 64'h1, 1'b1, 1'b1, 1'b1);
    wait_idle();
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_mp_sequencer.md
Name: csa_mp_sequencer

Overview:
- Multi-precision add sequencer built around one shared 16-bit carry-skip adder (`carry_skip16bit`).
- Accepts WORDS×16-bit operands through a valid/ready handshake.
- Feeds the adder one 16-bit word per cycle, LSW first, and chains the carry through a register.
- Returns the full-width sum and carry-out through a second valid/ready handshake.
- Sits between the operand source and the result consumer, so wide adds run without replicating the adder.

Parameters:
- WORDS, 4, number of 16-bit words per operand (≥1); total width N = 16*WORDS.
- IDX_W, $clog2(WORDS) (min 1), width of the word index counter; derived, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  sequencer can accept an operand bundle.
- a  in  N  operand A.
- b  in  N  operand B.
- cin  in  1  carry-in to word 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  N  result.
- cout  out  1  carry-out of the top word.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: all of the following are synchronous to clk.
  - Outputs: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Internal: idx=0, carry_reg=0, a_reg=b_reg=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a→a_reg, b→b_reg, cin→carry_reg; set idx=0; go to RUN.
  - In the capture cycle, sum/cout keep their previous values until overwritten word by word.
- RUN:
  - in_ready=0.
  - Each cycle the adder sees a_reg[idx], b_reg[idx], carry_reg.
  - At the clock edge: sum[idx] ← adder sum; carry_reg ← adder cout; idx ← idx+1.
  - When idx==WORDS-1: cout ← adder cout, idx ← 0, go to DONE.
- DONE:
  - out_valid=1; sum and cout are stable and held.
  - in_ready=0; in_valid is ignored.
  - On out_ready=1: go to IDLE, out_valid drops the next cycle.
- Latency:
  - out_valid rises exactly WORDS clock edges after the accepting edge.
  - Minimum initiation interval is WORDS+2 cycles (accept, WORDS RUN cycles, one DONE cycle with out_ready=1).
- Arithmetic:
  - Unsigned modulo 2^N; cout = bit N of a+b+cin.
  - The carry between words passes only through carry_reg; there is no combinational path across words.
- Boundaries:
  - WORDS=1: RUN lasts one cycle.
  - out_ready held high before DONE: no effect until DONE.
  - Back-pressure: out_ready low holds DONE indefinitely, with outputs stable.
  - in_valid while not ready: dropped; the source must hold it.
  - rst in any state, including mid-RUN: aborts the operation and applies reset values on the next edge; the partial result is discarded.
  - rst has priority over all handshakes.

Optional Feature:
- Macro CSA_MP_SEQ_SUB_EN.
- Defined:
  - Adds input port `op` (1 bit), captured with the operands.
  - op=1 computes a−b: b_reg is stored inverted and carry_reg is loaded with 1 (cin is ignored).
  - cout=1 means no borrow.
  - op=0 behaves exactly as the add-only build.
- Undefined: no `op` port; add only.

Decomposition:
- Package csa_seq_pkg contains:
  - State enum type (IDLE, RUN, DONE).
  - Constant ADDER_W=16.
- Sub-module: one instance of the existing carry_skip16bit; the sequencer owns all registers and the FSM.
- No other sub-modules.

Test Plan (WORDS=4, 64-bit):
- a=0x5, b=0x5, cin=1 → sum=0xB, cout=0; out_valid 4 edges after the accept edge.
- a=0x0000_0000_0000_FFFF, b=0x1, cin=0 → sum=0x0000_0000_0001_0000, cout=0 (inter-word carry through carry_reg).
- a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, cout=1 (carry ripples through all 4 words).
- Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new data → out_valid, sum, cout stable; in_ready=0; new data not captured; accepted only after out_ready and return to IDLE.
- Assert rst for 1 cycle after 2 RUN words → next cycle IDLE, in_ready=1, out_valid=0, sum=0, cout=0; a following a=0xC61F, b=0x18C, cin=1 → sum=0xC7AC, cout=0.
- CSA_MP_SEQ_SUB_EN:
  - op=1, a=0x10, b=0x1 → sum=0xF, cout=1.
  - op=1, a=0, b=1 → sum=0xFFFF_FFFF_FFFF_FFFF, cout=0.
